// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: opcode encodings, execution-stage state encoding
// and small opcode-class helpers used by the serial execution datapath.
package cpu_pkg;

   localparam int WIDTH_DEF = 8;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDI = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EXEC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Subtract-style ops: B inverted and carry preset to 1 (carry = no borrow).
   function automatic logic op_is_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_CMP);
   endfunction

   function automatic logic op_writes_c(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
   endfunction

   function automatic logic op_writes_z(input logic [3:0] op);
      return (op >= OP_LDI) && (op <= OP_CMP);
   endfunction

   // Ops that leave the accumulator untouched: A is rotated through a full turn.
   function automatic logic op_keeps_acc(input logic [3:0] op);
      return (op == OP_CMP) || !op_writes_z(op);
   endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// Combinational 1-bit ALU slice. Arithmetic ops ripple carry through cin/cout;
// all other ops pass the carry through unchanged.
module serial_alu_bit
   import cpu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [3:0] op,
   output logic       r,
   output logic       cout
);

   logic b_eff;

   always_comb begin
      b_eff = op_is_sub(op) ? ~b : b;
      r     = a;
      cout  = cin;
      case (op)
         OP_LDI: r = b;
         OP_ADD, OP_SUB, OP_CMP: begin
            r    = a ^ b_eff ^ cin;
            cout = (a & b_eff) | (a & cin) | (b_eff & cin);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         default: r = a;
      endcase
   end

endmodule

// File: rtl/serial_exec_unit.sv
// Bit-serial execution stage: latches opcode/imm8 on start, streams A and B
// LSB-first through a 1-bit ALU slice, then publishes the result and C/Z flags.
module serial_exec_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH+3:0] instr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] acc_out,
   output logic             flag_c,
   output logic             flag_z
);

   localparam int CW = $clog2(WIDTH);

   if (WIDTH != 8) begin : g_width_check
      $error("serial_exec_unit: only WIDTH=8 is supported");
   end

   // Handshake: start is accepted only while busy is low (IDLE); a start seen
   // while busy is dropped, not queued. Each accepted start yields exactly one
   // done pulse ten cycles later, with acc_out/flags already valid in that cycle.

   state_t           state, state_nxt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, a_nxt;
   logic [CW-1:0]    bitcnt;
   logic             carry_q, z_run_q;
   logic             alu_r, alu_cout, wbit, z_nxt;
   logic             accept, load_en, exec_en, last_bit;
   logic             unused_instr;

   assign unused_instr = ^instr[3:0];

   serial_alu_bit u_alu (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .r    (alu_r),
      .cout (alu_cout)
   );

   assign last_bit = (bitcnt == CW'(WIDTH - 1));
   assign wbit     = op_keeps_acc(op_q) ? a_q[0] : alu_r;
   assign a_nxt    = {wbit, a_q[WIDTH-1:1]};
   assign z_nxt    = z_run_q & ~alu_r;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)    state_nxt = ST_LOAD;
         ST_LOAD:               state_nxt = ST_EXEC;
         ST_EXEC: if (last_bit) state_nxt = ST_DONE;
         ST_DONE:               state_nxt = ST_IDLE;
         default:               state_nxt = ST_IDLE;
      endcase
   end

   // State-decoded outputs and datapath enables
   always_comb begin
      busy    = (state != ST_IDLE);
      done    = (state == ST_DONE);
      accept  = (state == ST_IDLE) && start;
      load_en = (state == ST_LOAD);
      exec_en = (state == ST_EXEC);
   end

   // Datapath. Result and flags are captured from the final shift so they are
   // already stable during the DONE cycle; A keeps shifting without touching acc_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= OP_NOP;
         a_q     <= '0;
         b_q     <= '0;
         bitcnt  <= '0;
         carry_q <= 1'b0;
         z_run_q <= 1'b0;
         acc_out <= '0;
         flag_c  <= 1'b0;
         flag_z  <= 1'b0;
      end else begin
         if (accept) begin
            op_q <= opcode;
            b_q  <= instr[WIDTH+3:4];
         end
         if (load_en) begin
            bitcnt  <= '0;
            carry_q <= op_is_sub(op_q);
            z_run_q <= 1'b1;
         end
         if (exec_en) begin
            a_q     <= a_nxt;
            b_q     <= b_q >> 1;
            carry_q <= alu_cout;
            z_run_q <= z_nxt;
            bitcnt  <= bitcnt + 1'b1;
            if (last_bit) begin
               acc_out <= a_nxt;
               if (op_writes_z(op_q)) flag_z <= z_nxt;
               if (op_writes_c(op_q)) flag_c <= alu_cout;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_exec_unit.sv
// Directed + random bench for serial_exec_unit: byte-level reference model,
// expected-result queue, per-operation latency/busy/stability checks.
module tb_serial_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  opcode = 4'd0;
   logic [11:0] instr = 12'd0;
   logic        busy, done, flag_c, flag_z;
   logic [7:0]  acc_out;

   int n_checks = 0;
   int n_pass   = 0;

   logic [9:0] exp_q[$];
   logic [7:0] model_a = 8'h00;
   logic       model_c = 1'b0;
   logic       model_z = 1'b0;

   serial_exec_unit #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .opcode  (opcode),
      .instr   (instr),
      .busy    (busy),
      .done    (done),
      .acc_out (acc_out),
      .flag_c  (flag_c),
      .flag_z  (flag_z)
   );

   // Clock
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference model, byte at a time
   task automatic model_step(input logic [3:0] op, input logic [7:0] imm);
      logic [8:0] sum;
      case (op)
         4'd1: begin model_a = imm; model_z = (imm == 8'h00); end
         4'd2: begin
            sum = {1'b0, model_a} + {1'b0, imm};
            model_a = sum[7:0]; model_c = sum[8]; model_z = (sum[7:0] == 8'h00);
         end
         4'd3: begin
            model_c = (model_a >= imm);
            model_a = model_a - imm;
            model_z = (model_a == 8'h00);
         end
         4'd4: begin model_a = model_a & imm; model_z = (model_a == 8'h00); end
         4'd5: begin model_a = model_a | imm; model_z = (model_a == 8'h00); end
         4'd6: begin model_a = model_a ^ imm; model_z = (model_a == 8'h00); end
         4'd7: begin model_c = (model_a >= imm); model_z = (model_a == imm); end
         default: ;
      endcase
   endtask

   // Driver + monitor for one operation. inject_at: cycle offset of an extra
   // start pulse (0 = none). rst_at: cycle offset of a reset abort (0 = none).
   task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] imm,
                         input int inject_at, input int rst_at);
      logic [9:0] prev, got, exp;
      int first_done, done_cnt, busy_bad, stable_bad;
      logic exp_busy;
      first_done = -1; done_cnt = 0; busy_bad = 0; stable_bad = 0; got = '0;
      @(negedge clk);
      prev   = {model_a, model_c, model_z};
      start  = 1'b1;
      opcode = op;
      instr  = {imm, 4'($urandom_range(0, 15))};
      model_step(op, imm);
      exp_q.push_back({model_a, model_c, model_z});
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (inject_at != 0 && i == inject_at) begin
            start = 1'b1; opcode = 4'd2; instr = 12'h010;
         end
         if (inject_at != 0 && i == inject_at + 1) start = 1'b0;
         if (rst_at != 0 && i == rst_at) begin
            rst = 1'b1;
            #1;
            check({name, " abort acc"}, 32'(acc_out), 32'h0);
            check({name, " abort flags"}, 32'({flag_c, flag_z}), 32'h0);
            check({name, " abort busy"}, 32'(busy), 32'h0);
            void'(exp_q.pop_back());
            model_a = 8'h00; model_c = 1'b0; model_z = 1'b0;
         end
         if (rst_at != 0 && i == rst_at + 2) rst = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            if (first_done < 0) begin first_done = i; got = {acc_out, flag_c, flag_z}; end
         end
         exp_busy = (rst_at != 0) ? (i < rst_at) : (i <= 10);
         if (busy !== exp_busy) busy_bad++;
         if (i < 10 && (rst_at == 0 || i < rst_at) && {acc_out, flag_c, flag_z} !== prev)
            stable_bad++;
      end
      check({name, " busy window"}, 32'(busy_bad), 32'h0);
      check({name, " outputs stable"}, 32'(stable_bad), 32'h0);
      if (rst_at != 0) begin
         check({name, " no done after abort"}, 32'(done_cnt), 32'h0);
      end else begin
         check({name, " done count"}, 32'(done_cnt), 32'h1);
         check({name, " done latency"}, 32'(first_done), 32'd10);
         if (exp_q.size() == 0) begin
            check({name, " scoreboard empty"}, 32'(exp_q.size()), 32'h1);
         end else begin
            exp = exp_q.pop_front();
            check({name, " acc_out"}, 32'(got[9:2]), 32'(exp[9:2]));
            check({name, " flag_c"}, 32'(got[1]), 32'(exp[1]));
            check({name, " flag_z"}, 32'(got[0]), 32'(exp[0]));
         end
      end
   endtask

   initial begin
      // 1: async reset with no clock edge
      #2 rst = 1'b1;
      #1;
      check("reset acc_out", 32'(acc_out), 32'h0);
      check("reset flag_c", 32'(flag_c), 32'h0);
      check("reset flag_z", 32'(flag_z), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 2-4: directed arithmetic / logic / compare
      run_op("ldi_5a", 4'd1, 8'h5A, 0, 0);
      run_op("add_c0", 4'd2, 8'hC0, 0, 0);
      run_op("sub_1a", 4'd3, 8'h1A, 0, 0);
      run_op("ldi_10", 4'd1, 8'h10, 0, 0);
      run_op("cmp_20", 4'd7, 8'h20, 0, 0);
      run_op("xor_10", 4'd6, 8'h10, 0, 0);
      run_op("ldi_f0", 4'd1, 8'hF0, 0, 0);
      run_op("or_0f",  4'd5, 8'h0F, 0, 0);
      run_op("and_3c", 4'd4, 8'h3C, 0, 0);
      run_op("cmp_eq", 4'd7, 8'h3C, 0, 0);
      run_op("nop_12", 4'd12, 8'hFF, 0, 0);
      run_op("sub_brw", 4'd3, 8'h40, 0, 0);

      // 5: start during execution is ignored
      run_op("ldi_33_inj", 4'd1, 8'h33, 4, 0);

      // 6: reset mid-EXEC aborts, then a normal load
      run_op("add_abort", 4'd2, 8'h77, 0, 6);
      run_op("ldi_0f", 4'd1, 8'h0F, 0, 0);

      // Random mix including reserved opcodes
      for (int k = 0; k < 10; k++)
         run_op($sformatf("rand%0d", k), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 0, 0);

      check("scoreboard drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
